// File: rtl/lcd_stream_writer.sv
// ============================================================================
// lcd_stream_writer : HD44780 instruction/string serialiser with timed E strobe
// Rev 1.0
// ============================================================================
`default_nettype none

module lcd_stream_writer #(
  parameter int CHARS  = 4,
  parameter int BUS4   = 0,
  parameter int T_AS   = 2,
  parameter int T_EH   = 12,
  parameter int T_H    = 2,
  parameter int T_NIB  = 2,
  parameter int T_WAIT = 2000,
  parameter int T_LONG = 82000
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_valid,
  output logic                         o_ready,
  input  logic                         i_chr,
  input  logic [7:0]                   i_cmd,
  input  logic [CHARS*8-1:0]           i_data,
  input  logic [$clog2(CHARS+1)-1:0]   i_len,
  output logic [7:0]                   o_data,
  output logic                         o_E,
  output logic                         o_RS,
  output logic                         o_RW,
  output logic                         o_done
);

  localparam int LW   = $clog2(CHARS + 1);
  localparam int M1   = (T_LONG > T_WAIT) ? T_LONG : T_WAIT;
  localparam int M2   = (M1 > T_EH) ? M1 : T_EH;
  localparam int M3   = (M2 > T_AS) ? M2 : T_AS;
  localparam int M4   = (M3 > T_H) ? M3 : T_H;
  localparam int MAXT = (M4 > T_NIB) ? M4 : T_NIB;
  localparam int CW   = $clog2(MAXT + 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    PULSE = 3'd2,
    HOLD  = 3'd3,
    GAP   = 3'd4,
    WAIT  = 3'd5,
    DONE  = 3'd6
  } state_t;

  state_t               state, state_n;
  logic [CW-1:0]        cnt, cnt_n;
  logic [LW-1:0]        idx, idx_n;
  logic                 nib, nib_n;
  logic                 chr_q;
  logic [7:0]           cmd_q;
  logic [CHARS*8-1:0]   data_q;
  logic [LW-1:0]        n_bytes;
  logic [7:0]           data_n;
  logic                 rs_n;
  logic                 accept;
  logic [LW-1:0]        len_clamped;
  logic                 long_wait;
  logic [CW-1:0]        wait_load;
  logic                 last_byte;

  function automatic logic [7:0] pick(input logic chr, input logic [7:0] cmd,
                                      input logic [CHARS*8-1:0] d, input logic [LW-1:0] k);
    pick = cmd;
    if (chr) begin
      for (int i = 0; i < CHARS; i++) begin
        if (k == LW'(i)) pick = d[i*8 +: 8];
      end
    end
  endfunction

  // In 4-bit mode only the upper half of the bus carries data.
  function automatic logic [7:0] bus(input logic [7:0] b, input logic low);
    if (BUS4 == 0) bus = b;
    else           bus = low ? {b[3:0], 4'h0} : {b[7:4], 4'h0};
  endfunction

  assign accept      = i_valid && o_ready;
  assign len_clamped = (i_len > LW'(CHARS)) ? LW'(CHARS) : i_len;
  assign long_wait   = !chr_q && (cmd_q[7:2] == 6'd0) && (cmd_q[1:0] != 2'd0);
  assign wait_load   = long_wait ? CW'(T_LONG - 1) : CW'(T_WAIT - 1);
  assign last_byte   = ({1'b0, idx} + (LW+1)'(1)) >= {1'b0, n_bytes};
  assign o_RW        = 1'b0;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    idx_n   = idx;
    nib_n   = nib;
    data_n  = o_data;
    rs_n    = o_RS;
    case (state)
      IDLE, DONE: begin
        state_n = IDLE;
        if (accept) begin
          idx_n = '0;
          nib_n = 1'b0;
          if (i_chr && (len_clamped == '0)) begin
            state_n = WAIT;
            cnt_n   = '0;
          end else begin
            state_n = SETUP;
            cnt_n   = CW'(T_AS - 1);
            rs_n    = i_chr;
            data_n  = bus(pick(i_chr, i_cmd, i_data, LW'(0)), 1'b0);
          end
        end
      end
      SETUP: begin
        if (cnt == '0) begin
          state_n = PULSE;
          cnt_n   = CW'(T_EH - 1);
        end else cnt_n = cnt - CW'(1);
      end
      PULSE: begin
        if (cnt == '0) begin
          state_n = HOLD;
          cnt_n   = CW'(T_H - 1);
        end else cnt_n = cnt - CW'(1);
      end
      HOLD: begin
        if (cnt == '0) begin
          if ((BUS4 != 0) && !nib) begin
            state_n = GAP;
            cnt_n   = CW'(T_NIB - 1);
          end else begin
            state_n = WAIT;
            cnt_n   = wait_load;
          end
        end else cnt_n = cnt - CW'(1);
      end
      GAP: begin
        if (cnt == '0) begin
          state_n = SETUP;
          cnt_n   = CW'(T_AS - 1);
          nib_n   = 1'b1;
          data_n  = bus(pick(chr_q, cmd_q, data_q, idx), 1'b1);
        end else cnt_n = cnt - CW'(1);
      end
      WAIT: begin
        if (cnt == '0) begin
          if (last_byte) begin
            state_n = DONE;
          end else begin
            state_n = SETUP;
            cnt_n   = CW'(T_AS - 1);
            idx_n   = idx + LW'(1);
            nib_n   = 1'b0;
            data_n  = bus(pick(chr_q, cmd_q, data_q, idx + LW'(1)), 1'b0);
          end
        end else cnt_n = cnt - CW'(1);
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      idx     <= '0;
      nib     <= 1'b0;
      chr_q   <= 1'b0;
      cmd_q   <= '0;
      data_q  <= '0;
      n_bytes <= '0;
      o_E     <= 1'b0;
      o_RS    <= 1'b0;
      o_data  <= '0;
      o_done  <= 1'b0;
      o_ready <= 1'b1;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      idx     <= idx_n;
      nib     <= nib_n;
      o_RS    <= rs_n;
      o_data  <= data_n;
      // Strobe/handshake outputs are decoded from the next state so they stay registered.
      o_E     <= (state_n == PULSE);
      o_done  <= (state_n == DONE);
      o_ready <= (state_n == IDLE) || (state_n == DONE);
      if (accept) begin
        chr_q   <= i_chr;
        cmd_q   <= i_cmd;
        data_q  <= i_data;
        n_bytes <= i_chr ? len_clamped : LW'(1);
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_lcd_stream_writer.sv
// ============================================================================
// tb_lcd_stream_writer : scoreboard bench, 8-bit (unit 0) and 4-bit (unit 1) instances
// Rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_lcd_stream_writer;

  localparam int CHARS  = 4;
  localparam int T_AS   = 1;
  localparam int T_EH   = 3;
  localparam int T_H    = 1;
  localparam int T_NIB  = 1;
  localparam int T_WAIT = 4;
  localparam int T_LONG = 10;

  typedef struct packed {
    logic        is_done;
    logic        rs;
    logic [7:0]  data;
    logic [31:0] at;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid [2];
  logic        ready [2];
  logic        chr   [2];
  logic        e     [2];
  logic        rs    [2];
  logic        rw    [2];
  logic        done  [2];
  logic [7:0]  cmd   [2];
  logic [7:0]  dout  [2];
  logic [31:0] din   [2];
  logic [2:0]  len   [2];

  ev_t         sbq [2][$];
  int          checks = 0;
  int          errs = 0;
  int unsigned cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    lcd_stream_writer #(
      .CHARS(CHARS), .BUS4(g), .T_AS(T_AS), .T_EH(T_EH), .T_H(T_H),
      .T_NIB(T_NIB), .T_WAIT(T_WAIT), .T_LONG(T_LONG)
    ) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid[g]), .o_ready(ready[g]),
      .i_chr(chr[g]), .i_cmd(cmd[g]), .i_data(din[g]), .i_len(len[g]),
      .o_data(dout[g]), .o_E(e[g]), .o_RS(rs[g]), .o_RW(rw[g]), .o_done(done[g])
    );
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errs++;
    $display("FAIL %s: event or wait outside expectation", name);
  endtask

  task automatic pop_check(input int u, input logic want_done);
    ev_t ev;
    if (sbq[u].size() == 0) begin
      fail($sformatf("u%0d spurious_%s at cycle %0d", u, want_done ? "done" : "E", cyc));
      return;
    end
    ev = sbq[u].pop_front();
    chk($sformatf("u%0d event_kind", u), 32'(want_done), 32'(ev.is_done));
    chk($sformatf("u%0d event_cycle", u), cyc, ev.at);
    if (!want_done) begin
      chk($sformatf("u%0d strobe_data", u), 32'(dout[u]), 32'(ev.data));
      chk($sformatf("u%0d strobe_rs", u), 32'(rs[u]), 32'(ev.rs));
    end
  endtask

  // Push the strobes and completion a request should produce; lat is hand-computed.
  task automatic expect_req(input int u, input int unsigned acc, input logic r, input int n,
                            input logic [31:0] b, input int unsigned lat);
    int   bb;
    logic [7:0] bj;
    bb = (u == 0) ? 0 : 2*(T_AS+T_EH+T_H) + T_NIB - (T_AS+T_EH+T_H);
    bb = bb + T_AS + T_EH + T_H + ((!r && b[7:0] >= 8'h01 && b[7:0] <= 8'h03) ? T_LONG : T_WAIT);
    for (int j = 0; j < n; j++) begin
      bj = b[8*j +: 8];
      if (u == 0) begin
        sbq[u].push_back(ev_t'{1'b0, r, bj, 32'(acc + j*bb + T_AS)});
      end else begin
        sbq[u].push_back(ev_t'{1'b0, r, {bj[7:4], 4'h0}, 32'(acc + j*bb + T_AS)});
        sbq[u].push_back(ev_t'{1'b0, r, {bj[3:0], 4'h0},
                               32'(acc + j*bb + 2*T_AS + T_EH + T_H + T_NIB)});
      end
    end
    sbq[u].push_back(ev_t'{1'b1, 1'b0, 8'h00, 32'(acc + lat)});
  endtask

  task automatic send(input int u, input logic c, input logic [7:0] cm, input logic [31:0] d,
                      input logic [2:0] l, output int unsigned acc);
    int guard = 0;
    @(negedge clk);
    valid[u] = 1'b1; chr[u] = c; cmd[u] = cm; din[u] = d; len[u] = l;
    while (!ready[u] && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 300) fail($sformatf("u%0d ready_timeout", u));
    @(posedge clk);
    #1;
    acc = cyc;
    valid[u] = 1'b0; chr[u] = ~c; cmd[u] = 8'hFF; din[u] = '1; len[u] = 3'd2;
  endtask

  // Monitor: pops the scoreboard on every E rise and every o_done pulse.
  logic e_prev [2];
  int   hi_cnt [2];
  initial begin
    e_prev[0] = 1'b0; e_prev[1] = 1'b0; hi_cnt[0] = 0; hi_cnt[1] = 0;
    forever begin
      @(negedge clk);
      for (int u = 0; u < 2; u++) begin
        if (!rst_n) begin
          e_prev[u] = 1'b0;
          hi_cnt[u] = 0;
        end else begin
          if (sbq[u].size() != 0 && !done[u])
            chk($sformatf("u%0d ready_low_busy", u), 32'(ready[u]), 32'd0);
          if (e[u] && !e_prev[u]) pop_check(u, 1'b0);
          if (e[u]) hi_cnt[u]++;
          else if (e_prev[u]) begin
            chk($sformatf("u%0d E_width", u), 32'(hi_cnt[u]), 32'(T_EH));
            hi_cnt[u] = 0;
          end
          if (done[u]) pop_check(u, 1'b1);
          e_prev[u] = e[u];
        end
      end
    end
  end

  initial begin
    int unsigned a;
    int unsigned a2;
    int guard;
    for (int u = 0; u < 2; u++) begin
      valid[u] = 1'b0; chr[u] = 1'b0; cmd[u] = 8'h00; din[u] = '0; len[u] = 3'd0;
    end
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      chk($sformatf("u%0d rst_ready", u), 32'(ready[u]), 32'd1);
      chk($sformatf("u%0d rst_E", u), 32'(e[u]), 32'd0);
      chk($sformatf("u%0d rst_data", u), 32'(dout[u]), 32'd0);
      chk($sformatf("u%0d rst_RS", u), 32'(rs[u]), 32'd0);
      chk($sformatf("u%0d rst_RW", u), 32'(rw[u]), 32'd0);
      chk($sformatf("u%0d rst_done", u), 32'(done[u]), 32'd0);
    end
    rst_n = 1'b1;

    // 8-bit instructions: short and long execution delays
    send(0, 1'b0, 8'h38, 32'h0, 3'd0, a);
    chk("s1 RS_at_accept", 32'(rs[0]), 32'd0);
    chk("s1 data_at_accept", 32'(dout[0]), 32'h38);
    expect_req(0, a, 1'b0, 1, 32'h38, 9);
    send(0, 1'b0, 8'h01, 32'h0, 3'd5, a); expect_req(0, a, 1'b0, 1, 32'h01, 15);
    send(0, 1'b0, 8'h03, 32'h0, 3'd0, a); expect_req(0, a, 1'b0, 1, 32'h03, 15);
    send(0, 1'b0, 8'h04, 32'h0, 3'd0, a); expect_req(0, a, 1'b0, 1, 32'h04, 9);

    // 8-bit string of 3 characters
    send(0, 1'b1, 8'h00, 32'h00434241, 3'd3, a);
    expect_req(0, a, 1'b1, 3, 32'h00434241, 27);

    // 4-bit bus: one character, then a long instruction
    send(1, 1'b1, 8'h00, 32'h0000004A, 3'd1, a);
    chk("s4 data_at_accept", 32'(dout[1]), 32'h40);
    expect_req(1, a, 1'b1, 1, 32'h0000004A, 15);
    send(1, 1'b0, 8'h02, 32'h0, 3'd0, a); expect_req(1, a, 1'b0, 1, 32'h02, 21);

    // Empty string keeps the bus untouched, then back-to-back clamped string and command
    send(0, 1'b0, 8'h38, 32'h0, 3'd0, a); expect_req(0, a, 1'b0, 1, 32'h38, 9);
    send(0, 1'b1, 8'h00, 32'h44434241, 3'd0, a);
    expect_req(0, a, 1'b1, 0, 32'h0, 1);
    chk("s5 len0_RS_kept", 32'(rs[0]), 32'd0);
    chk("s5 len0_data_kept", 32'(dout[0]), 32'h38);
    send(0, 1'b1, 8'h00, 32'h44434241, 3'd7, a2);
    expect_req(0, a2, 1'b1, 4, 32'h44434241, 36);
    chk("s5 b2b_after_len0", a2, a + 2);
    a = a2;
    send(0, 1'b0, 8'h06, 32'h0, 3'd0, a2);
    expect_req(0, a2, 1'b0, 1, 32'h06, 9);
    chk("s5 b2b_after_string", a2, a + 37);

    // Reset while E is high on the second character
    send(0, 1'b1, 8'h00, 32'h5A595857, 3'd4, a);
    expect_req(0, a, 1'b1, 4, 32'h5A595857, 36);
    while (cyc < a + 11) @(negedge clk);
    chk("s6 E_high_before_reset", 32'(e[0]), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("s6 rst_E", 32'(e[0]), 32'd0);
    chk("s6 rst_data", 32'(dout[0]), 32'd0);
    chk("s6 rst_RS", 32'(rs[0]), 32'd0);
    chk("s6 rst_done", 32'(done[0]), 32'd0);
    chk("s6 rst_ready", 32'(ready[0]), 32'd1);
    sbq[0].delete();
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b1;
    send(0, 1'b0, 8'h38, 32'h0, 3'd0, a); expect_req(0, a, 1'b0, 1, 32'h38, 9);

    guard = 0;
    while ((sbq[0].size() != 0 || sbq[1].size() != 0) && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    @(negedge clk);
    chk("u0 scoreboard_drained", 32'(sbq[0].size()), 32'd0);
    chk("u1 scoreboard_drained", 32'(sbq[1].size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", checks, errs);
    $finish;
  end

endmodule

`default_nettype wire
